// File: rtl/clefia_f0f1_round_ctrl.sv
// Round sequencer for the CLEFIA GFN F0/F1 XOR/bypass stage: steps through LOAD, the
// pipelined rounds and FINAL, driving sel, round-key addresses, whitening selects and state strobes.
module clefia_f0f1_round_ctrl #(
    parameter int NUM_ROUNDS = 18,
    parameter int PIPE_LAT   = 2,
    parameter int RK_ADDR_W  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 dec,
    output logic                 busy,
    output logic                 done,
    output logic                 load_pt,
    output logic                 wk_en,
    output logic                 wk_sel,
    output logic                 sel,
    output logic                 issue,
    output logic                 capture,
    output logic                 permute,
    output logic [4:0]           round,
    output logic [RK_ADDR_W-1:0] rk_addr0,
    output logic [RK_ADDR_W-1:0] rk_addr1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        FINAL = 2'd3
    } state_t;

    localparam int              PH_W     = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(PIPE_LAT);
    localparam logic [4:0]      RND_LAST = 5'(NUM_ROUNDS - 1);

    state_t              state_r, state_s;
    logic [PH_W-1:0]     phase_r, phase_s;
    logic [4:0]          round_r, round_s;
    logic                dec_r, dec_s;
    logic [4:0]          r_eff_s;
    logic [RK_ADDR_W-1:0] rk0_s, rk1_s;

    // Next-state, phase/round counters and latched direction
    always_comb begin
        state_s = state_r;
        phase_s = phase_r;
        round_s = round_r;
        dec_s   = dec_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = LOAD;
                    dec_s   = dec;
                    round_s = 5'd0;
                    phase_s = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                state_s = ROUND;
                phase_s = '0;
            end
            ROUND: begin
                if (phase_r == PH_LAST) begin
                    phase_s = '0;
                    if (round_r == RND_LAST) begin
                        state_s = FINAL;
                    end else begin
                        round_s = round_r + 5'd1;
                    end
                end else begin
                    phase_s = phase_r + PH_W'(1);
                end
            end
            FINAL: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Decrypt walks the key schedule from the last round back to the first
    always_comb begin
        if (dec_s) begin
            r_eff_s = RND_LAST - round_s;
        end else begin
            r_eff_s = round_s;
        end
        rk0_s = RK_ADDR_W'({r_eff_s, 1'b0});
        rk1_s = rk0_s + RK_ADDR_W'(1);
    end

    // Sequencer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            phase_r <= '0;
            round_r <= 5'd0;
            dec_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            phase_r <= phase_s;
            round_r <= round_s;
            dec_r   <= dec_s;
        end
    end

    // Output registers, decoded from the upcoming state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            load_pt  <= 1'b0;
            wk_en    <= 1'b0;
            wk_sel   <= 1'b0;
            sel      <= 1'b0;
            issue    <= 1'b0;
            capture  <= 1'b0;
            permute  <= 1'b0;
            rk_addr0 <= '0;
            rk_addr1 <= '0;
        end else begin
            busy    <= (state_s != IDLE);
            done    <= (state_s == FINAL);
            load_pt <= (state_s == LOAD);
            wk_en   <= (state_s == LOAD) || (state_s == FINAL);
            wk_sel  <= ((state_s == LOAD) && dec_s) || ((state_s == FINAL) && !dec_s);
            sel     <= (state_s == ROUND);
            issue   <= (state_s == ROUND) && (phase_s == '0);
            capture <= (state_s == ROUND) && (phase_s == PH_LAST);
            permute <= (state_s == ROUND) && (phase_s == PH_LAST) && (round_s != RND_LAST);
            if ((state_s == LOAD) || (state_s == ROUND)) begin
                rk_addr0 <= rk0_s;
                rk_addr1 <= rk1_s;
            end else begin
                rk_addr0 <= rk_addr0;
                rk_addr1 <= rk_addr1;
            end
        end
    end

    assign round = round_r;

endmodule

// File: tb/tb_clefia_f0f1_round_ctrl.sv
// Directed bench for clefia_f0f1_round_ctrl: default 18-round/PIPE_LAT=2 instance plus a
// 1-round/PIPE_LAT=0 instance, every output compared cycle by cycle against hand-derived timing.
module tb_clefia_f0f1_round_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0, dec_a = 1'b0;
    logic       start_b = 1'b0, dec_b = 1'b0;
    logic       busy_a, done_a, load_pt_a, wk_en_a, wk_sel_a, sel_a, issue_a, capture_a, permute_a;
    logic       busy_b, done_b, load_pt_b, wk_en_b, wk_sel_b, sel_b, issue_b, capture_b, permute_b;
    logic [4:0] round_a, round_b;
    logic [5:0] rk0_a, rk1_a, rk0_b, rk1_b;
    logic [31:0] obs_a, obs_b;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    clefia_f0f1_round_ctrl #(.NUM_ROUNDS(18), .PIPE_LAT(2), .RK_ADDR_W(6)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .dec(dec_a),
        .busy(busy_a), .done(done_a), .load_pt(load_pt_a), .wk_en(wk_en_a), .wk_sel(wk_sel_a),
        .sel(sel_a), .issue(issue_a), .capture(capture_a), .permute(permute_a),
        .round(round_a), .rk_addr0(rk0_a), .rk_addr1(rk1_a)
    );

    clefia_f0f1_round_ctrl #(.NUM_ROUNDS(1), .PIPE_LAT(0), .RK_ADDR_W(6)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .dec(dec_b),
        .busy(busy_b), .done(done_b), .load_pt(load_pt_b), .wk_en(wk_en_b), .wk_sel(wk_sel_b),
        .sel(sel_b), .issue(issue_b), .capture(capture_b), .permute(permute_b),
        .round(round_b), .rk_addr0(rk0_b), .rk_addr1(rk1_b)
    );

    assign obs_a = {6'd0, busy_a, done_a, load_pt_a, wk_en_a, wk_sel_a, sel_a, issue_a,
                    capture_a, permute_a, round_a, rk0_a, rk1_a};
    assign obs_b = {6'd0, busy_b, done_b, load_pt_b, wk_en_b, wk_sel_b, sel_b, issue_b,
                    capture_b, permute_b, round_b, rk0_b, rk1_b};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected packed outputs at cycle cyc of a block whose start was sampled at the end of cycle 0
    function automatic logic [31:0] exp_vec(input int cyc, input bit d, input int nr, input int pl);
        int  last = 1 + nr * (pl + 1);
        int  r = 0, ph = 0, re, a0;
        bit  bsy = 0, dn = 0, ld = 0, wke = 0, wks = 0, sl = 0, iss = 0, cap = 0, prm = 0;
        if (cyc == 1) begin
            bsy = 1; ld = 1; wke = 1; wks = d;
        end else if (cyc <= last) begin
            r   = (cyc - 2) / (pl + 1);
            ph  = (cyc - 2) % (pl + 1);
            bsy = 1; sl = 1;
            iss = (ph == 0);
            cap = (ph == pl);
            prm = cap && (r != nr - 1);
        end else if (cyc == last + 1) begin
            r = nr - 1; bsy = 1; dn = 1; wke = 1; wks = !d;
        end else begin
            r = nr - 1;
        end
        re = d ? (nr - 1 - r) : r;
        a0 = (2 * re) % 64;
        return {6'd0, bsy, dn, ld, wke, wks, sl, iss, cap, prm, 5'(r), 6'(a0), 6'(a0 + 1)};
    endfunction

    // One block on the 18-round instance; noisy = stray start pulses at 10/56 and dec toggling
    task automatic run_a(input string tag, input bit d, input int ncyc, input int rst_at,
                         input bit noisy, input int exp_done);
        int dones = 0;
        start_a = 1'b1;
        dec_a   = d;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(posedge clk);
            #1;
            start_a = noisy && (cyc == 10 || cyc == 56);
            dec_a   = noisy ? cyc[0] : d;
            rst     = (rst_at > 0) && (cyc == rst_at);
            if (done_a) dones++;
            if ((rst_at > 0) && (cyc > rst_at)) begin
                check($sformatf("%s_c%0d", tag, cyc), obs_a, 32'd0);
            end else begin
                check($sformatf("%s_c%0d", tag, cyc), obs_a, exp_vec(cyc, d, 18, 2));
            end
        end
        dec_a = 1'b0;
        check($sformatf("%s_done_count", tag), 32'(dones), 32'(exp_done));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", obs_a, 32'd0);
        check("reset_b", obs_b, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_a", obs_a, 32'd0);

        run_a("enc", 1'b0, 57, 0, 1'b0, 1);
        run_a("dec", 1'b1, 57, 0, 1'b0, 1);
        run_a("noise", 1'b0, 57, 0, 1'b1, 1);
        run_a("restart", 1'b1, 57, 0, 1'b0, 1);
        run_a("rst_mid", 1'b0, 25, 20, 1'b0, 0);
        run_a("after_rst", 1'b0, 57, 0, 1'b0, 1);

        start_b = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(posedge clk);
            #1;
            start_b = 1'b0;
            check($sformatf("tiny_c%0d", cyc), obs_b, exp_vec(cyc, 1'b0, 1, 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
